// File: rtl/tgen_pkg.sv
// Shared types and reset key constants for the tag stream generator.
package tgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } tgen_state_e;

  localparam logic [3:0] TGEN_BF_INIT  = 4'b1101;
  localparam logic [7:0] TGEN_ROT_INIT = {2'd3, 2'd0, 2'd1, 2'd2};

endpackage

// File: rtl/tgen_seg_xform.sv
// Per-segment transform: optional bitwise inversion followed by a left rotate.
module tgen_seg_xform #(
  parameter int SEG_W = 4,
  parameter int ROT_W = 2
) (
  input  logic [SEG_W-1:0] seg_i,
  input  logic             flip_i,
  input  logic [ROT_W-1:0] rot_i,
  output logic [SEG_W-1:0] seg_o
);

  logic [SEG_W-1:0]   flipped;
  logic [2*SEG_W-1:0] dbl;

  // Rotating a doubled copy leaves the rotated word in the upper half.
  always_comb begin
    flipped = flip_i ? ~seg_i : seg_i;
    dbl     = {flipped, flipped} << (int'(rot_i) % SEG_W);
    seg_o   = dbl[2*SEG_W-1:SEG_W];
  end

endmodule

// File: rtl/tag_stream_gen.sv
// Keyed tag generator: XOR-accumulates flipped/rotated segments of a message
// and presents the tag with a compare against an expected value.
//
// state    | meaning
// ST_IDLE  | waiting for first beat; key_load accepted here
// ST_ACCUM | message in progress, one beat per cycle
// ST_DONE  | tag presented until tag_valid && tag_ready
module tag_stream_gen
  import tgen_pkg::*;
#(
  parameter int                       SEG_W    = 4,
  parameter int                       NUM_SEG  = 4,
  parameter int                       ROT_W    = $clog2(SEG_W),
  parameter logic [NUM_SEG-1:0]       BF_INIT  = TGEN_BF_INIT,
  parameter logic [NUM_SEG*ROT_W-1:0] ROT_INIT = TGEN_ROT_INIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_load,
  input  logic [NUM_SEG-1:0]       key_bf,
  input  logic [NUM_SEG*ROT_W-1:0] key_rot,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [SEG_W-1:0]         s_data,
  input  logic                     s_last,
  input  logic [SEG_W-1:0]         exp_tag,
  output logic                     tag_valid,
  input  logic                     tag_ready,
  output logic [SEG_W-1:0]         tag,
  output logic                     tag_match
);

  localparam int K_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  tgen_state_e              state_q, state_d;
  logic [K_W-1:0]           k_q, k_d, k_sel;
  logic [SEG_W-1:0]         acc_q, acc_d, acc_base, seg_x;
  logic                     match_q, match_d;
  logic [NUM_SEG-1:0]       key_bf_q, key_bf_d;
  logic [NUM_SEG*ROT_W-1:0] key_rot_q, key_rot_d;
  logic                     beat;

  assign s_ready   = ((state_q == ST_IDLE) && !key_load) || (state_q == ST_ACCUM);
  assign beat      = s_valid && s_ready;
  // A beat taken in IDLE starts a fresh message: slot 0, empty accumulator.
  assign k_sel     = (state_q == ST_IDLE) ? '0 : k_q;
  assign acc_base  = (state_q == ST_IDLE) ? '0 : acc_q;
  assign tag_valid = (state_q == ST_DONE);
  assign tag       = acc_q;
  assign tag_match = match_q;

  tgen_seg_xform #(
    .SEG_W(SEG_W),
    .ROT_W(ROT_W)
  ) u_xform (
    .seg_i (s_data),
    .flip_i(key_bf_q[k_sel]),
    .rot_i (key_rot_q[k_sel*ROT_W +: ROT_W]),
    .seg_o (seg_x)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    match_d   = match_q;
    key_bf_d  = key_bf_q;
    key_rot_d = key_rot_q;

    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          key_bf_d  = key_bf;
          key_rot_d = key_rot;
        end
      end
      ST_ACCUM: ;
      ST_DONE: begin
        if (tag_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (beat) begin
      acc_d = acc_base ^ seg_x;
      if (s_last) begin
        state_d = ST_DONE;
        k_d     = '0;
        match_d = (acc_d == exp_tag);
      end else begin
        state_d = ST_ACCUM;
        k_d     = (k_sel == K_W'(NUM_SEG - 1)) ? '0 : k_sel + K_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      match_q   <= 1'b0;
      key_bf_q  <= BF_INIT;
      key_rot_q <= ROT_INIT;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      match_q   <= match_d;
      key_bf_q  <= key_bf_d;
      key_rot_q <= key_rot_d;
    end
  end

endmodule

// File: tb/tb_tag_stream_gen.sv
// Self-checking bench for tag_stream_gen: directed key/tag cases plus a
// randomized stream checked every cycle against a message-level model.
module tb_tag_stream_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_load, s_valid, s_last, tag_ready;
  logic [3:0] key_bf, s_data, exp_tag;
  logic [7:0] key_rot;
  logic       s_ready, tag_valid, tag_match;
  logic [3:0] tag;

  tag_stream_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .key_bf   (key_bf),
    .key_rot  (key_rot),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .exp_tag  (exp_tag),
    .tag_valid(tag_valid),
    .tag_ready(tag_ready),
    .tag      (tag),
    .tag_match(tag_match)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  // Message-level model: keys, whether a message is open, collected beats.
  logic [3:0] m_bf = 4'b1101;
  logic [7:0] m_rot = 8'hC6;
  bit         m_in_msg = 1'b0;
  bit         m_done = 1'b0;
  logic [3:0] m_beats[$];
  logic [3:0] m_tag = 4'h0;
  bit         m_match = 1'b0;

  logic [3:0] md[16];

  function automatic logic [3:0] model_tag(input logic [3:0] bf, input logic [7:0] rot,
                                           input logic [3:0] beats[$]);
    int acc = 0;
    for (int i = 0; i < beats.size(); i++) begin
      int slot = i % 4;
      int a = int'(beats[i]);
      int r = int'((rot >> (2 * slot)) & 8'h3);
      if (((bf >> slot) & 4'h1) != 0) a = a ^ 15;
      a = ((a << r) | (a >> (4 - r))) & 15;
      acc = acc ^ a;
    end
    return 4'(acc);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_msg = 1'b0;
      m_done   = 1'b0;
      m_beats.delete();
      m_bf     = 4'b1101;
      m_rot    = 8'hC6;
      m_tag    = 4'h0;
      m_match  = 1'b0;
    end else if (m_done) begin
      if (tag_ready) m_done = 1'b0;
    end else if (!m_in_msg && key_load) begin
      m_bf  = key_bf;
      m_rot = key_rot;
    end else if (s_valid) begin
      m_beats.push_back(s_data);
      if (s_last) begin
        m_tag    = model_tag(m_bf, m_rot, m_beats);
        m_match  = (m_tag == exp_tag);
        m_done   = 1'b1;
        m_in_msg = 1'b0;
        m_beats.delete();
      end else begin
        m_in_msg = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      chk("s_ready", s_ready, !m_done && (m_in_msg || !key_load));
      chk("tag_valid", tag_valid, m_done);
      if (m_done) begin
        chk("tag", tag, m_tag);
        chk("tag_match", tag_match, m_match);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_msg(input logic [63:0] w);
    for (int i = 0; i < 16; i++) md[i] = w[4*i +: 4];
  endtask

  task automatic send_msg(input int n, input logic [3:0] exp, input logic [3:0] want_tag,
                          input logic want_match, input int hold, input bit kl_mid,
                          input string nm);
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = md[i];
      s_last  = (i == n - 1);
      exp_tag = exp;
      if (kl_mid && i > 0) begin
        key_load = 1'b1;
        key_bf   = 4'h0;
        key_rot  = 8'h00;
      end
      guard = 0;
      do begin
        @(negedge clk);
        acc = s_ready;
        tick();
        guard++;
      end while (!acc && guard < 20);
      if (!acc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_accept: beat %0d not accepted, expected accept within 20 cycles", nm, i);
      end
    end
    s_valid  = 1'b0;
    s_last   = 1'b0;
    key_load = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, tag_valid, 1'b1);
    chk({nm, "_tag"}, tag, want_tag);
    chk({nm, "_match"}, tag_match, want_match);
    tick();
    if (hold > 0) begin
      s_valid = 1'b1;
      s_data  = 4'($urandom);
      s_last  = 1'($urandom);
      repeat (hold) tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    tag_ready = 1'b1;
    tick();
    tag_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_idle"}, tag_valid, 1'b0);
    tick();
  endtask

  initial begin
    key_load = 1'b0; key_bf = 4'h0; key_rot = 8'h00;
    s_valid = 1'b0; s_data = 4'h0; s_last = 1'b0; exp_tag = 4'h0; tag_ready = 1'b0;
    #1;
    chk("rst_tag_valid", tag_valid, 1'b0);
    chk("rst_tag", tag, 4'h0);
    chk("rst_tag_match", tag_match, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    run_cmp = 1'b1;

    load_msg(64'h0);    send_msg(4, 4'h0, 4'hF, 1'b0, 0, 1'b0, "zero4");
    load_msg(64'h4321); send_msg(4, 4'hE, 4'hE, 1'b1, 10, 1'b0, "seq4_hold");
    load_msg(64'h0);    send_msg(5, 4'h0, 4'h0, 1'b1, 0, 1'b0, "zero5_wrap");
    load_msg(64'h1);    send_msg(1, 4'hB, 4'hB, 1'b1, 0, 1'b0, "single");
    load_msg(64'h4321); send_msg(4, 4'hE, 4'hE, 1'b1, 2, 1'b1, "kl_mid");

    key_load = 1'b1; key_bf = 4'h0; key_rot = 8'h00;
    s_valid = 1'b1; s_data = 4'h7; s_last = 1'b1;
    @(negedge clk);
    chk("kl_blocks_ready", s_ready, 1'b0);
    tick();
    key_load = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    load_msg(64'h4321); send_msg(4, 4'h4, 4'h4, 1'b1, 0, 1'b0, "kl_idle");

    s_valid = 1'b1; s_last = 1'b0; s_data = 4'h1;
    tick();
    s_data = 4'h2;
    tick();
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_tag_valid", tag_valid, 1'b0);
    chk("midrst_tag", tag, 4'h0);
    chk("midrst_tag_match", tag_match, 1'b0);
    tick();
    rst_n = 1'b1;
    load_msg(64'h4321); send_msg(4, 4'hE, 4'hE, 1'b1, 0, 1'b0, "after_rst");

    for (int c = 0; c < 3000; c++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = 4'($urandom);
      s_last    = ($urandom_range(0, 3) == 0);
      exp_tag   = 4'($urandom);
      key_load  = ($urandom_range(0, 7) == 0);
      key_bf    = 4'($urandom);
      key_rot   = 8'($urandom);
      tag_ready = ($urandom_range(0, 2) != 0);
      tick();
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end
    s_valid = 1'b0; key_load = 1'b0; tag_ready = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
